prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 6 +
 rtl/prog_loader_uart_rx.sv | 81 ++++++++
 rtl/prog_loader.sv | 94 +++++++++
 tb/tb_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encodings and constants for the UART program loader
package prog_loader_pkg;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CNT_H, L_CNT_L, L_DAT_H, L_DAT_L, L_DONE, L_ERR} ld_state_t;
    localparam logic [7:0] SYNC_BYTE = 8'h55;
endpackage

// File: rtl/prog_loader_uart_rx.sv
// uart_rx: 8N1 receiver with two-flop input synchronizer, one-cycle byte_valid / frame_err pulses
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t st, st_n;
    logic [1:0] sync;
    logic prev, rxs;
    logic [CW-1:0] baud, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] sh_n;
    logic bv_n, fe_n;

    assign rxs = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= R_IDLE;
            sync <= 2'b11;
            prev <= 1'b1;
            baud <= '0;
            bit_idx <= '0;
            byte_out <= '0;
            byte_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            st <= st_n;
            sync <= {sync[0], rx};
            prev <= rxs;
            baud <= baud_n;
            bit_idx <= bit_n;
            byte_out <= sh_n;
            byte_valid <= bv_n;
            frame_err <= fe_n;
        end
    end

    always_comb begin
        st_n = st;
        baud_n = baud + CW'(1);
        bit_n = bit_idx;
        sh_n = byte_out;
        bv_n = 1'b0;
        fe_n = 1'b0;
        case (st)
            R_IDLE: begin
                baud_n = '0;
                if (prev && !rxs) st_n = R_START;
            end
            R_START: if (baud == HALF) begin
                baud_n = '0;
                st_n = rxs ? R_IDLE : R_DATA;
            end
            R_DATA: if (baud == FULL) begin
                baud_n = '0;
                sh_n = {rxs, byte_out[7:1]};
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) st_n = R_STOP;
            end
            R_STOP: if (baud == FULL) begin
                baud_n = '0;
                st_n = R_IDLE;
                bv_n = rxs;
                fe_n = !rxs;
            end
            default: st_n = R_IDLE;
        endcase
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a sync/count/word stream over UART and writes it into instruction memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);
    ld_state_t state, state_n;
    logic [7:0] rx_byte, hi, hi_n;
    logic byte_valid, frame_err, we_n;
    logic [15:0] cnt, cnt_n, addr_n, data_n;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .byte_out(rx_byte),
        .byte_valid(byte_valid),
        .frame_err(frame_err)
    );

    assign busy = state inside {L_CNT_H, L_CNT_L, L_DAT_H, L_DAT_L};
    assign done = state == L_DONE;
    assign err = state == L_ERR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= L_IDLE;
            cnt <= '0;
            hi <= '0;
            mem_addr <= BASE_ADDR;
            mem_data <= '0;
            mem_we <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            hi <= hi_n;
            mem_addr <= addr_n;
            mem_data <= data_n;
            mem_we <= we_n;
        end
    end

    // the write strobe cycle stays in L_DAT_L so busy covers it; advance happens the cycle after
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        hi_n = hi;
        addr_n = mem_addr;
        data_n = mem_data;
        we_n = 1'b0;
        case (state)
            L_IDLE, L_DONE: if (byte_valid && rx_byte == SYNC_BYTE) begin
                state_n = L_CNT_H;
                addr_n = BASE_ADDR;
            end
            L_CNT_H: if (byte_valid) begin
                cnt_n[15:8] = rx_byte;
                state_n = L_CNT_L;
            end
            L_CNT_L: if (byte_valid) begin
                cnt_n[7:0] = rx_byte;
                state_n = ({cnt[15:8], rx_byte} == 16'd0) ? L_DONE : L_DAT_H;
            end
            L_DAT_H: if (byte_valid) begin
                hi_n = rx_byte;
                state_n = L_DAT_L;
            end
            L_DAT_L: if (mem_we) begin
                addr_n = mem_addr + 16'd1;
                cnt_n = cnt - 16'd1;
                state_n = (cnt == 16'd1) ? L_DONE : L_DAT_H;
            end else if (byte_valid) begin
                we_n = 1'b1;
                data_n = {hi, rx_byte};
            end
            default: ;
        endcase
        if (frame_err && busy) begin
            state_n = L_ERR;
            we_n = 1'b0;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven, random and reset-sequence checks of prog_loader against a stream model
module tb_prog_loader;
    localparam int CPB = 8;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [15:0] a_addr, a_data, b_addr, b_data;
    logic a_we, a_busy, a_done, a_err, b_we, b_busy, b_done, b_err;

    prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .rx(rx), .mem_addr(a_addr), .mem_data(a_data),
        .mem_we(a_we), .busy(a_busy), .done(a_done), .err(a_err)
    );
    prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .rx(rx), .mem_addr(b_addr), .mem_data(b_data),
        .mem_we(b_we), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, d;
        logic bat, baft, daft;
    } wr_t;

    typedef struct {
        string name;
        logic [63:0] s;
        int len, bad, inst, nw;
        logic [15:0] a0, d0, a1, d1;
        logic busy, done, err;
    } vec_t;

    wr_t log_a[$], log_b[$];
    wr_t wa, wb;
    logic pa = 1'b0, pb = 1'b0;
    logic [7:0] stim_q[$];
    logic ok_q[$];
    logic [32:0] exp_q[$];
    logic m_busy, m_done, m_err;
    int n_cmp = 0, n_bad = 0;

    always @(negedge clk) begin
        if (pa && log_a.size() > 0) begin
            wa = log_a.pop_back();
            wa.baft = a_busy;
            wa.daft = a_done;
            log_a.push_back(wa);
        end
        if (a_we) begin
            wa.a = a_addr; wa.d = a_data; wa.bat = a_busy; wa.baft = 1'b0; wa.daft = 1'b0;
            log_a.push_back(wa);
        end
        pa <= a_we;
    end

    always @(negedge clk) begin
        if (pb && log_b.size() > 0) begin
            wb = log_b.pop_back();
            wb.baft = b_busy;
            wb.daft = b_done;
            log_b.push_back(wb);
        end
        if (b_we) begin
            wb.a = b_addr; wb.d = b_data; wb.bat = b_busy; wb.baft = 1'b0; wb.daft = 1'b0;
            log_b.push_back(wb);
        end
        pb <= b_we;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ok);
        send_bit(1'b0);
        for (int j = 0; j < 8; j++) send_bit(b[j]);
        send_bit(ok);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_stream();
        for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k], ok_q[k]);
        repeat (20) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        stim_q.push_back(b);
        ok_q.push_back(1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " a_we"}, 32'(a_we), 32'd0);
        chk({tag, " a_busy"}, 32'(a_busy), 32'd0);
        chk({tag, " a_done"}, 32'(a_done), 32'd0);
        chk({tag, " a_err"}, 32'(a_err), 32'd0);
        chk({tag, " a_addr"}, 32'(a_addr), 32'h0000);
        chk({tag, " a_data"}, 32'(a_data), 32'h0000);
        chk({tag, " b_addr"}, 32'(b_addr), 32'hFFFF);
        chk({tag, " b_data"}, 32'(b_data), 32'h0000);
        chk({tag, " b_busy"}, 32'(b_busy), 32'd0);
        chk({tag, " b_err"}, 32'(b_err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset(tag);
        rst = 1'b0;
        log_a.delete();
        log_b.delete();
    endtask

    // Stream-level reference: each sync outside a load starts a new load of 2+2*count bytes
    task automatic model(input logic [15:0] base);
        int i, n, need;
        logic [7:0] pl[$];
        logic [32:0] e;
        exp_q.delete();
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        n = stim_q.size();
        i = 0;
        while (i < n && !m_err) begin
            if (!ok_q[i] || stim_q[i] != 8'h55) begin
                i++;
                continue;
            end
            i++;
            pl.delete();
            m_busy = 1'b1; m_done = 1'b0;
            need = 2;
            while (i < n && pl.size() < need) begin
                if (!ok_q[i]) begin
                    m_err = 1'b1;
                    m_busy = 1'b0;
                    break;
                end
                pl.push_back(stim_q[i]);
                i++;
                if (pl.size() == 2) need = 2 + 2 * int'({pl[0], pl[1]});
            end
            for (int w = 0; 2 * w + 3 < pl.size(); w++) begin
                e = {(2 * w + 4 == need), base + 16'(w), pl[2 + 2 * w], pl[3 + 2 * w]};
                exp_q.push_back(e);
            end
            if (!m_err && pl.size() == need) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic cmp_log(input string tag, input int inst);
        wr_t l[$];
        logic bs, dn, er;
        if (inst == 0) begin
            l = log_a; bs = a_busy; dn = a_done; er = a_err;
        end else begin
            l = log_b; bs = b_busy; dn = b_done; er = b_err;
        end
        chk({tag, " nwr"}, 32'(l.size()), 32'(exp_q.size()));
        for (int k = 0; k < l.size() && k < exp_q.size(); k++) begin
            chk($sformatf("%s w%0d addr", tag, k), 32'(l[k].a), 32'(exp_q[k][31:16]));
            chk($sformatf("%s w%0d data", tag, k), 32'(l[k].d), 32'(exp_q[k][15:0]));
            chk($sformatf("%s w%0d busy_at", tag, k), 32'(l[k].bat), 32'd1);
            chk($sformatf("%s w%0d busy_after", tag, k), 32'(l[k].baft), 32'(!exp_q[k][32]));
            chk($sformatf("%s w%0d done_after", tag, k), 32'(l[k].daft), 32'(exp_q[k][32]));
        end
        chk({tag, " busy"}, 32'(bs), 32'(m_busy));
        chk({tag, " done"}, 32'(dn), 32'(m_done));
        chk({tag, " err"}, 32'(er), 32'(m_err));
    endtask

    task automatic gen();
        logic [7:0] b;
        int cw;
        stim_q.delete();
        ok_q.delete();
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            push(b == 8'h55 ? 8'h56 : b);
        end
        repeat ($urandom_range(1, 2)) begin
            push(8'h55);
            cw = $urandom_range(0, 3);
            push(8'h00);
            push(8'(cw));
            repeat (cw * 2) push(8'($urandom));
            if ($urandom_range(0, 2) == 0) push(8'h3C);
        end
        if ($urandom_range(0, 3) == 0) ok_q[$urandom_range(0, ok_q.size() - 1)] = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        logic [63:0] s;
        logic [32:0] e;
        vt[0] = '{"r29 two words", 64'h5500021234ABCD00, 7, -1, 0, 2, 16'h0000, 16'h1234, 16'h0001, 16'hABCD, 1'b0, 1'b1, 1'b0};
        vt[1] = '{"r30 zero count", 64'h5500000000000000, 3, -1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{"r31 leading junk", 64'h00FF550001BEEF00, 7, -1, 0, 1, 16'h0000, 16'hBEEF, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{"r32 addr wrap", 64'h5500021111222200, 7, -1, 1, 2, 16'hFFFF, 16'h1111, 16'h0000, 16'h2222, 1'b0, 1'b1, 1'b0};
        vt[4] = '{"r33 err in data", 64'h5500021234ABCD55, 8, 5, 0, 1, 16'h0000, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1};
        vt[5] = '{"err in count", 64'h55AA00021234ABCD, 8, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{"err in idle", 64'h12550001CAFE0000, 6, 0, 0, 1, 16'h0000, 16'hCAFE, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0};

        for (int v = 0; v < 7; v++) begin
            do_reset({vt[v].name, " reset"});
            stim_q.delete();
            ok_q.delete();
            s = vt[v].s;
            for (int k = 0; k < vt[v].len; k++) begin
                stim_q.push_back(s[63 - 8 * k -: 8]);
                ok_q.push_back(k != vt[v].bad);
            end
            send_stream();
            exp_q.delete();
            if (vt[v].nw > 0) begin
                e = {(vt[v].nw == 1) && vt[v].done, vt[v].a0, vt[v].d0};
                exp_q.push_back(e);
            end
            if (vt[v].nw > 1) begin
                e = {vt[v].done, vt[v].a1, vt[v].d1};
                exp_q.push_back(e);
            end
            m_busy = vt[v].busy; m_done = vt[v].done; m_err = vt[v].err;
            cmp_log(vt[v].name, vt[v].inst);
        end

        for (int r = 0; r < 8; r++) begin
            do_reset($sformatf("rand%0d reset", r));
            gen();
            send_stream();
            model(16'h0000);
            cmp_log($sformatf("rand%0d A", r), 0);
            model(16'hFFFF);
            cmp_log($sformatf("rand%0d B", r), 1);
        end

        do_reset("r34 pre");
        stim_q.delete();
        ok_q.delete();
        push(8'h55); push(8'h00); push(8'h02); push(8'h12); push(8'h34);
        send_stream();
        chk("r34 busy before", 32'(a_busy), 32'd1);
        chk("r34 data before", 32'(a_data), 32'h1234);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk_reset("r34 mid");
        repeat (CPB * 4) @(negedge clk);
        rst = 1'b0;
        log_a.delete();
        log_b.delete();
        stim_q.delete();
        ok_q.delete();
        push(8'h55); push(8'h00); push(8'h01); push(8'hBE); push(8'hEF);
        send_stream();
        model(16'h0000);
        cmp_log("r34 after A", 0);
        model(16'hFFFF);
        cmp_log("r34 after B", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
